uartin: RTL and testbench
=========================

Name: uartin

Overview:
UART receiver and the receive-side counterpart of uartout. It takes a 2-wire-less serial line (rx), recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) at CDIV clocks per bit, and pushes each good byte into a downstream FIFO through an active-low write strobe. It sits between the board RX pin and the chargen FIFO, and uses the same bit timing as uartout so the two loop back directly.

Parameters:
CDIV, 8, clocks per bit period; must be >= 4; mid-bit point is CDIV/2 (integer division).

Ports:
clk     input   1  system clock; all logic on rising edge
rst     input   1  synchronous reset, active-high
rx      input   1  serial line, idle high, asynchronous to clk
n_full  input   1  FIFO full, active-low (0 = full)
data    output  8  last received byte; valid while n_wr low, held afterwards
n_wr    output  1  FIFO write strobe, active-low, one clk wide
ferr    output  1  framing-error pulse, one clk wide
ovr     output  1  overrun pulse, one clk wide (byte arrived while FIFO full)
busy    output  1  high while in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state changes occur on the rising edge of clk.
- Reset (rst=1 at an edge): state=IDLE, synchronizer FFs=1, cnt=0, bit index=0, shift=0, data=0, n_wr=1, ferr=0, ovr=0, busy=0. Reset mid-frame abandons the frame with no strobe or error pulse.
- rx passes through a 2-FF synchronizer, giving rx_s (2-cycle delay). All decisions use rx_s only.
- The cnt width is $clog2(CDIV). Bit index is 3 bits.
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START:
  - cnt increments each clk.
  - When cnt==CDIV/2-1, sample rx_s.
  - Sample 1 -> IDLE (glitch reject, no pulses).
  - Sample 0 -> DATA, cnt=0, index=0.
- DATA:
  - cnt increments, and wraps to 0 at CDIV-1.
  - At cnt==CDIV-1, sample rx_s into shift MSB with a right shift, so the first bit received ends as data[0]. Then index++.
  - After the 8th sample (index 7) -> STOP, cnt=0.
- STOP:
  - At cnt==CDIV-1, sample rx_s. Samples are mid-bit throughout.
  - Sample 1, n_full==1: data<=shift, n_wr=0 for the next cycle only -> IDLE.
  - Sample 1, n_full==0: data<=shift, n_wr stays 1, ovr=1 for one cycle -> IDLE.
  - Sample 0: ferr=1 for one cycle, data unchanged, no n_wr -> BREAK.
- BREAK:
  - Wait for rx_s==1, then -> IDLE. This prevents a held-low line from retriggering frames.
- Strobes are registered outputs. n_wr, ferr and ovr are mutually exclusive and never asserted in consecutive cycles.
- data is updated in the same edge that asserts n_wr/ovr, and is stable for at least one full frame afterwards.
- Latency:
  - rx falling edge -> n_wr low = 2 + CDIV/2 + 9*CDIV (+/-1) clks.
  - CDIV=8: 78 clks.
- Back-to-back frames: IDLE is re-entered about half a bit before the end of the stop bit, so a start bit immediately after the stop bit is detected without loss.
- n_full is sampled only at the stop-bit decision. The block never stalls the line, and the byte is simply dropped with ovr.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset: rst=1 for 2 clks with rx=1 -> data=0x00, n_wr=1, ferr=0, ovr=0, busy=0. Deassert rst -> remains IDLE.
- Single frame: send 0x53 ('S') at 8 clks/bit, n_full=1 -> exactly one n_wr low pulse about 78 clks after the start edge, with data=0x53 during and after it, and no ferr/ovr.
- Back-to-back frames: 0x53 followed immediately by 0x74 ('t') with no idle gap -> two n_wr pulses 80 clks apart, data=0x53 then 0x74. Also loop uartout (CDIV=8) tx into rx and check that the bytes match.
- Glitch reject: rx low for 3 clks then high -> returns to IDLE, no n_wr, ferr or ovr. busy is high for at most 6 clks.
- Framing error and break:
  - 0x41 with stop bit 0, then rx held low for 40 clks -> one ferr pulse, no n_wr, data unchanged, busy high until rx returns high.
  - A following 0x42 is received correctly.
- Overrun and reset mid-frame:
  - 0x55 with n_full=0 -> ovr pulse, no n_wr, data=0x55.
  - rst asserted halfway through the next frame -> all outputs return to their reset values, no pulses, and a subsequent 0x6B is received correctly.

Source files
------------

// File: rtl/uartin.sv
// rtl/uartin.sv - 8N1 UART receiver feeding a FIFO through an active-low write strobe
module uartin #(
    parameter int CDIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       n_full,
    output logic [7:0] data,
    output logic       n_wr,
    output logic       ferr,
    output logic       ovr,
    output logic       busy
);

    localparam int CW = (CDIV > 1) ? $clog2(CDIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CDIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CDIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          n_wr_q, n_wr_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        n_wr_d    = 1'b1;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_q + 1'b1;
                // Re-check the start bit at its centre so short glitches are ignored
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        n_wr_d  = !n_full;
                        ovr_d   = !n_full;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                // A line held low must return high before another start bit counts
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            n_wr_q    <= 1'b1;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            n_wr_q    <= n_wr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign data = data_q;
    assign n_wr = n_wr_q;
    assign ferr = ferr_q;
    assign ovr  = ovr_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uartin.sv
// tb/tb_uartin.sv - self-checking bench for uartin
module tb_uartin;

    localparam int CDIV = 8;
    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_OVR  = 2'd1;
    localparam logic [1:0] K_FERR = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       n_full;
    logic [7:0] data;
    logic       n_wr;
    logic       ferr;
    logic       ovr;
    logic       busy;

    uartin #(.CDIV(CDIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .n_full (n_full),
        .data   (data),
        .n_wr   (n_wr),
        .ferr   (ferr),
        .ovr    (ovr),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] dat;
        int         t0;
    } exp_t;

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        logic       nfull;
        int         hold_low;
        int         gap;
    } vec_t;

    exp_t       exp_q[$];
    exp_t       e;
    exp_t       got;
    vec_t       vecs[9];
    int         checks;
    int         errors;
    int         cyc;
    int         nev;
    int         wr_prev;
    int         wr_last;
    int         busy_cnt;
    logic       prev_ev;
    logic [1:0] act_kind;
    logic [7:0] model_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CDIV) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic nf);
        n_full = nf;
        e.t0   = cyc;
        if (stop && nf) begin
            e.kind = K_WR;
            e.dat  = d;
            model_data = d;
        end else if (stop) begin
            e.kind = K_OVR;
            e.dat  = d;
            model_data = d;
        end else begin
            e.kind = K_FERR;
            e.dat  = model_data;
        end
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
        send_bit(stop);
        check("event_pending", exp_q.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        wr_prev    = 0;
        wr_last    = 0;
        prev_ev    = 1'b0;
        model_data = 8'h00;
        rst        = 1'b1;
        rx         = 1'b1;
        n_full     = 1'b1;

        vecs = '{
            '{8'h00, 1'b1, 1'b1, 0, 5},
            '{8'hFF, 1'b1, 1'b1, 0, 0},
            '{8'hA5, 1'b1, 1'b1, 0, 3},
            '{8'h41, 1'b0, 1'b1, 40, 10},
            '{8'h42, 1'b1, 1'b1, 0, 10},
            '{8'h55, 1'b1, 1'b0, 0, 10},
            '{8'h3C, 1'b1, 1'b1, 0, 0},
            '{8'hC3, 1'b1, 1'b1, 0, 7},
            '{8'h81, 1'b1, 1'b1, 0, 10}
        };

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (!rst) begin
                    nev = int'(!n_wr) + int'(ferr) + int'(ovr);
                    if (nev > 1) begin
                        check("strobe_exclusive", nev, 1);
                    end
                    if (nev > 0) begin
                        check("strobe_gap", prev_ev, 1'b0);
                        act_kind = ferr ? K_FERR : (ovr ? K_OVR : K_WR);
                        if (exp_q.size() == 0) begin
                            check("unexpected_event", {30'd0, act_kind}, 32'hFFFF_FFFF);
                        end else begin
                            got = exp_q.pop_front();
                            check("event_kind", act_kind, got.kind);
                            check("event_data", data, got.dat);
                            check_range("event_latency", cyc - got.t0, 77, 79);
                        end
                        if (!n_wr) begin
                            wr_prev = wr_last;
                            wr_last = cyc;
                        end
                    end
                    prev_ev = (nev > 0);
                end else begin
                    prev_ev = 1'b0;
                end
            end
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data, 8'h00);
        check("rst_n_wr", n_wr, 1'b1);
        check("rst_ferr", ferr, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(10);
        check("idle_busy", busy, 1'b0);
        check("idle_n_wr", n_wr, 1'b1);

        // Back-to-back 'S' then 't'
        send_frame(8'h53, 1'b1, 1'b1);
        send_frame(8'h74, 1'b1, 1'b1);
        idle(4);
        check("b2b_spacing", wr_last - wr_prev, 80);
        check("b2b_data_held", data, 8'h74);

        // Glitch reject
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (busy) busy_cnt++;
        end
        check_range("glitch_busy_cycles", busy_cnt, 1, 6);
        check("glitch_busy_end", busy, 1'b0);

        // Table of frames
        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].dat, vecs[v].stop, vecs[v].nfull);
            if (vecs[v].hold_low > 0) begin
                idle(vecs[v].hold_low);
                check("break_busy", busy, 1'b1);
            end
            rx     = 1'b1;
            n_full = 1'b1;
            if (vecs[v].gap > 0) begin
                idle(vecs[v].gap);
                check("gap_busy", busy, 1'b0);
                check("gap_data_held", data, model_data);
                check("gap_n_wr", n_wr, 1'b1);
            end
        end

        // Reset halfway through a frame
        idle(5);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        idle(2);
        model_data = 8'h00;
        check("midrst_data", data, 8'h00);
        check("midrst_n_wr", n_wr, 1'b1);
        check("midrst_ferr", ferr, 1'b0);
        check("midrst_ovr", ovr, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(100);
        check("midrst_quiet_busy", busy, 1'b0);
        send_frame(8'h6B, 1'b1, 1'b1);
        idle(10);
        check("final_data", data, 8'h6B);
        check("final_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
